// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction-fetch stage.
//   NOP_INSTR     - word loaded into IF/ID on a bubble
//   ctr_t         - 2-bit saturating branch counter (SNT, WNT, WT, ST)
//   btb_entry_t   - one BTB entry {valid, tag, target, ctr}
//   ctr_inc/dec   - saturating counter steps
// Tag and target fields are sized for the widest supported address
// (MAX_ADDR_WIDTH); narrower configurations zero-extend into them.
package fetch_pkg;

    localparam int          MAX_ADDR_WIDTH = 32;
    localparam logic [31:0] NOP_INSTR      = 32'hE1A00000;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef struct packed {
        logic                      valid;
        logic [MAX_ADDR_WIDTH-1:0] tag;
        logic [MAX_ADDR_WIDTH-1:0] target;
        ctr_t                      ctr;
    } btb_entry_t;

    function automatic ctr_t ctr_inc(input ctr_t c);
        return (c == ST) ? ST : ctr_t'(c + 2'd1);
    endfunction

    function automatic ctr_t ctr_dec(input ctr_t c);
        return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit saturating counters.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   lookup_pc                     - fetch PC to predict for
//   lookup_taken, lookup_target   - prediction (target valid when taken)
//   upd_en, upd_pc, upd_taken,
//   upd_target                    - resolved branch from execute
// Macro BTB_BYPASS_EN: forward a same-index update into the lookup
// (write-first). Without it the lookup sees stored state only.
module branch_target_buffer
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int BTB_ENTRIES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  lookup_taken,
    output logic [ADDR_WIDTH-1:0] lookup_target,
    input  logic                  upd_en,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [ADDR_WIDTH-1:0] upd_target
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = ADDR_WIDTH - 2 - IDX;

    btb_entry_t mem [BTB_ENTRIES];

    logic [IDX-1:0]   lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    btb_entry_t       lk_entry, upd_old, upd_entry;
    logic             upd_hit, upd_we;

    // Byte-offset bits never take part in indexing or tagging.
    logic unused_bits;
    assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lk_idx  = lookup_pc[2 +: IDX];
    assign lk_tag  = lookup_pc[ADDR_WIDTH-1 -: TAG_W];
    assign upd_idx = upd_pc[2 +: IDX];
    assign upd_tag = upd_pc[ADDR_WIDTH-1 -: TAG_W];

    always_comb begin
        upd_old   = mem[upd_idx];
        upd_hit   = upd_old.valid && (upd_old.tag == MAX_ADDR_WIDTH'(upd_tag));
        upd_entry = upd_old;
        upd_we    = 1'b0;
        if (upd_en) begin
            if (upd_hit) begin
                upd_we        = 1'b1;
                upd_entry.ctr = upd_taken ? ctr_inc(upd_old.ctr) : ctr_dec(upd_old.ctr);
                if (upd_taken)
                    upd_entry.target = MAX_ADDR_WIDTH'(upd_target);
            end else if (upd_taken) begin
                upd_we    = 1'b1;
                upd_entry = '{valid:  1'b1,
                              tag:    MAX_ADDR_WIDTH'(upd_tag),
                              target: MAX_ADDR_WIDTH'(upd_target),
                              ctr:    WT};
            end
        end
    end

    always_comb begin
        lk_entry = mem[lk_idx];
`ifdef BTB_BYPASS_EN
        if (upd_we && (upd_idx == lk_idx))
            lk_entry = upd_entry;
`endif
        lookup_taken  = lk_entry.valid && (lk_entry.tag == MAX_ADDR_WIDTH'(lk_tag))
                        && (lk_entry.ctr inside {WT, ST});
        lookup_target = lk_entry.target[ADDR_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++)
                mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
        end else if (upd_we) begin
            mem[upd_idx] <= upd_entry;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, predicts next PC via
// the BTB, corrects mispredictions from execute and fills IF/ID.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   imem_addr / imem_rd   - instruction memory address / same-cycle data
//   stall_f, stall_d      - hold PC / hold IF/ID
//   flush_d               - bubble IF/ID
//   ex_*                  - resolved branch from execute with its prediction
//   mispredict_e          - combinational redirect indication
//   instr_d, pc_d, valid_d, pred_taken_d, pred_target_d - IF/ID contents
// Macro BTB_BYPASS_EN: enables write-first forwarding inside the BTB.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    BTB_ENTRIES = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rd,
    input  logic                   stall_f,
    input  logic                   stall_d,
    input  logic                   flush_d,
    input  logic                   ex_branch,
    input  logic [ADDR_WIDTH-1:0]  ex_pc,
    input  logic                   ex_taken,
    input  logic [ADDR_WIDTH-1:0]  ex_target,
    input  logic                   ex_pred_taken,
    input  logic [ADDR_WIDTH-1:0]  ex_pred_target,
    output logic                   mispredict_e,
    output logic [INSTR_WIDTH-1:0] instr_d,
    output logic [ADDR_WIDTH-1:0]  pc_d,
    output logic                   valid_d,
    output logic                   pred_taken_d,
    output logic [ADDR_WIDTH-1:0]  pred_target_d
);

    logic [ADDR_WIDTH-1:0] pc_f, pred_next, correct_pc, btb_target;
    logic                  pred_taken_f;

    branch_target_buffer #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk           (clk),
        .reset         (reset),
        .lookup_pc     (pc_f),
        .lookup_taken  (pred_taken_f),
        .lookup_target (btb_target),
        .upd_en        (ex_branch),
        .upd_pc        (ex_pc),
        .upd_taken     (ex_taken),
        .upd_target    (ex_target)
    );

    assign imem_addr  = pc_f;
    assign pred_next  = pred_taken_f ? btb_target : pc_f + ADDR_WIDTH'(4);
    assign correct_pc = ex_taken ? ex_target : ex_pc + ADDR_WIDTH'(4);

    // Target mismatch only matters when the branch was actually taken.
    assign mispredict_e = ex_branch &&
                          ((ex_taken != ex_pred_taken) ||
                           (ex_taken && (ex_target != ex_pred_target)));

    // A redirect overrides stall_f: the wrong-path PC must never be held.
    always_ff @(posedge clk) begin
        if (reset)
            pc_f <= RESET_PC;
        else if (mispredict_e)
            pc_f <= correct_pc;
        else if (!stall_f)
            pc_f <= pred_next;
    end

    always_ff @(posedge clk) begin
        if (reset || flush_d || mispredict_e) begin
            instr_d       <= INSTR_WIDTH'(NOP_INSTR);
            pc_d          <= '0;
            valid_d       <= 1'b0;
            pred_taken_d  <= 1'b0;
            pred_target_d <= '0;
        end else if (!stall_d) begin
            instr_d       <= imem_rd;
            pc_d          <= pc_f;
            valid_d       <= 1'b1;
            pred_taken_d  <= pred_taken_f;
            pred_target_d <= pred_next;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined processor: owns the program counter, drives the instruction memory address, and captures the returned word into the IF/ID pipeline register. Next-PC selection uses a direct-mapped branch target buffer with 2-bit saturating counters. The unit corrects mispredictions reported by the execute stage and honours the hazard unit's stall and flush controls.

## Interface
- ADDR_WIDTH, 32, PC / instruction-memory address width
- INSTR_WIDTH, 32, instruction word width
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2
- RESET_PC, 32'h0, PC value after reset
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_addr  out  ADDR_WIDTH  fetch address to instruction memory (= pc_f)
- imem_rd  in  INSTR_WIDTH  instruction word from instruction memory, combinational, same cycle
- stall_f  in  1  hold PC
- stall_d  in  1  hold IF/ID register
- flush_d  in  1  load bubble into IF/ID register
- ex_branch  in  1  execute holds a resolved branch this cycle
- ex_pc  in  ADDR_WIDTH  PC of that branch
- ex_taken  in  1  actual outcome
- ex_target  in  ADDR_WIDTH  actual taken target
- ex_pred_taken  in  1  prediction carried down the pipe with the branch
- ex_pred_target  in  ADDR_WIDTH  predicted target carried down the pipe
- mispredict_e  out  1  combinational; to hazard unit for E-stage flush
- instr_d, pc_d  out  INSTR_WIDTH / ADDR_WIDTH  IF/ID contents
- valid_d, pred_taken_d  out  1  IF/ID contents
- pred_target_d  out  ADDR_WIDTH  IF/ID contents

## Operation
- IDX = log2(BTB_ENTRIES). Index = pc[2+:IDX]. Tag = pc[ADDR_WIDTH-1:2+IDX]. Entry = {valid, tag, target, ctr[1:0]}.
- Lookup on pc_f: hit = valid && tag match. pred_taken_f = hit && ctr[1]. pred_next = pred_taken_f ? target : pc_f+4. Addition is modulo 2^ADDR_WIDTH.
- mispredict_e = ex_branch && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)).
- correct_pc = ex_taken ? ex_target : ex_pc+4.
- Counter states: SNT=00, WNT=01, WT=10, ST=11. Taken increments and saturates at 11; not-taken decrements and saturates at 00.
- BTB update when ex_branch:
  - Hit on ex_pc: update the counter; write target if taken.
  - Miss and taken: allocate entry with valid=1, tag, target, ctr=WT.
  - Miss and not taken: no write.
- PC register priority: reset → RESET_PC; mispredict_e → correct_pc (overrides stall_f); stall_f → hold; else pred_next.
- IF/ID register priority:
  - reset, flush_d or mispredict_e → bubble: instr_d=32'hE1A00000 (NOP), valid_d=0, pc_d=0, pred_taken_d=0, pred_target_d=0.
  - stall_d → hold.
  - Else capture {imem_rd, pc_f, 1, pred_taken_f, pred_next}.

## Timing
- Reset values: pc_f=imem_addr=RESET_PC; IF/ID holds the bubble; all BTB valid bits 0, all counters WNT. mispredict_e depends only on inputs.
- Fetch-to-decode latency is 1 cycle. The instruction at pc_f appears on instr_d after the next edge.
- Mispredict penalty: the redirect lands on the edge where mispredict_e is high. The wrong-path instruction in F that cycle is squashed into IF/ID. The hazard unit flushes E.
- BTB write takes effect at the edge. A lookup in the same cycle at the same index sees the old entry (no bypass unless BTB_BYPASS_EN is defined).
- Reset asserted mid-operation wins over every other control on that edge.
- stall_f=1 with stall_d=0 is legal: IF/ID recaptures the same PC.

## Configuration
- BTB_BYPASS_EN defined: when ex_branch writes the index equal to pc_f's index in the same cycle, the lookup uses the post-update entry (write-first forwarding).
- BTB_BYPASS_EN undefined: the lookup reads stored state only (read-first). The BTB remains fully functional.

## Structure
- Shared package fetch_pkg holds:
  - NOP_INSTR = 32'hE1A00000
  - ctr_t enum {SNT, WNT, WT, ST}
  - btb_entry_t struct
  - functions ctr_inc and ctr_dec
- Sub-module branch_target_buffer: BTB storage, lookup port, update port, reset clear, optional bypass.
- fetch_unit keeps the PC register, next-PC mux, mispredict logic and IF/ID register.

## Test plan
- Reset: hold reset 2 cycles, release → imem_addr=0, then 4, 8, 12 on successive edges; after reset valid_d=0 and instr_d=E1A00000.
- Cold taken branch: ex_branch=1, ex_pc=0x10, ex_taken=1, ex_target=0x40, ex_pred_taken=0 → mispredict_e=1, next imem_addr=0x40, valid_d=0. A later fetch at 0x10 predicts 0x40 (ctr=WT).
- Counter saturation: resolve 0x10 not-taken twice → the next fetch of 0x10 predicts 0x14. Taken three times → ST, and one not-taken still predicts taken.
- Stall vs. redirect: stall_f=stall_d=1 hold PC and IF/ID for 3 cycles. mispredict_e during a stall still redirects the PC and bubbles IF/ID.
- Aliasing: branches at 0x10 and 0x50 (same index, BTB_ENTRIES=16) → the second allocation evicts the first, and 0x10 then misses (predicts 0x14).
- Same-cycle update and lookup at the same index: the prediction uses the new entry only with BTB_BYPASS_EN; run the test in both builds.
